ysyx_040066_mem_arbiter: RTL
============================

// Module: ysyx_040066_mem_arbiter
// PURPOSE
//  Shares one external memory port between three cache-side requesters:
//  - icache line/single read (I)
//  - dcache read/refill (DR)
//  - dcache write-back/uncached write (DW)
//  Sits between the two cache_top instances and the SoC bus, replacing the
//  three separate ins_/rd_/wr_ ports with one mem_ port. Fixed priority
//  (DW > DR > I) with an anti-starvation counter for I.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive D grants while I waits before I is forced next (1..15)
// PORTS
//  clk                       in   1    clock; all state on posedge
//  rst                       in   1    asynchronous reset, active-high
//  ins_req, ins_burst        in   1    I request (held until done); burst = 8-beat line read
//  ins_addr                  in   64   I address
//  ins_ready, ins_last       out  1    I beat valid / final beat
//  rd_req, rd_burst          in   1    DR request / 8-beat line read
//  rd_len                    in   3    DR access size, log2 bytes
//  rd_addr                   in   64   DR address
//  rd_ready, rd_last         out  1    DR beat valid / final beat
//  wr_req, wr_burst          in   1    DW request / 512-bit line write
//  wr_len                    in   3    DW size, log2 bytes
//  wr_mask                   in   8    DW byte strobes (single-beat only)
//  wr_addr                   in   64   DW address
//  wr_data                   in   512  DW data; single-beat uses [63:0]
//  wr_ready                  out  1    DW complete
//  rsp_err                   out  1    error for current granted completion
//  rsp_data                  out  64   read beat data (shared by I and DR)
//  mem_req, mem_we, mem_burst out 1    bus request / write / burst
//  mem_len                   out  3    size, log2 bytes
//  mem_mask                  out  8    write strobes
//  mem_addr                  out  64   address
//  mem_wdata                 out  512  write data
//  mem_ready, mem_last, mem_err in 1   bus beat/completion, final read beat, error
//  mem_rdata                 in   64   read beat data
//  grant                     out  2    0 idle, 1 I, 2 DR, 3 DW (equals state)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-burst):
//    - state=IDLE, starve_cnt=0
//    - all outputs 0
//    - in-flight transfer abandoned
//  - FSM states: IDLE, GNT_I, GNT_DR, GNT_DW.
//  - IDLE: registers a grant from reqs sampled that cycle.
//    - Priority: wr_req > rd_req > ins_req.
//    - Exception: starve_cnt==STARVE_LIMIT and ins_req -> GNT_I.
//    - No req: stay IDLE.
//  - Latency: req seen in IDLE cycle N -> mem_req=1 from N+1; no combinational req->mem_req path.
//  - Bus outputs while granted:
//    - mem_req=1; fields muxed live from the granted requester.
//    - GNT_I: mem_we=0, mem_len=3, mem_mask=0.
//    - GNT_DR: mem_we=0.
//    - GNT_DW: mem_we=1.
//    - IDLE: all mem_* = 0.
//  - Return path:
//    - Granted requester's ready = mem_ready; last = mem_last (reads only).
//    - rsp_data = mem_rdata.
//    - rsp_err = mem_err & mem_ready & (state!=IDLE).
//    - Non-granted readys are 0.
//  - Completion:
//    - Reads: mem_ready & mem_last (single-beat reads also assert last).
//    - Writes: mem_ready.
//    - On completion -> IDLE. Mandatory one-cycle IDLE bubble so the requester can drop req.
//  - starve_cnt update at each grant:
//    - D grant while ins_req=1: +1, saturating at STARVE_LIMIT.
//    - Grant to I, or ins_req=0 at grant: cleared.
//  - Requester dropping req mid-grant (protocol violation): grant held, mem_req stays 1 until completion.
//  - mem_err does not shorten a burst; completion still requires last.
// TESTING
//  - Reset: rst=1 mid GNT_DR burst beat 3 -> next edge all outputs 0, grant=0; no further rd_ready.
//  - Simultaneous ins_req, rd_req(burst), wr_req(burst) in cycle 0:
//    - grant=3 at cycle 1, mem_we=1.
//    - After wr_ready: IDLE 1 cycle -> grant=2.
//    - 8 rd_ready beats, rd_last on 8th -> IDLE -> grant=1.
//  - Starvation: ins_req held, DR re-requested each bubble -> exactly 4 DR grants, then I granted;
//    starve_cnt=0 after.
//  - Single-beat I read addr 0x8000_0004:
//    - mem_len=3, mem_burst=0.
//    - mem_ready+mem_last with rdata 0x1234 -> ins_ready=1, ins_last=1, rsp_data=0x1234, same cycle.
//  - Error: DW single write, mem_err=1 with mem_ready -> wr_ready=1, rsp_err=1; rd_ready/ins_ready stay 0.
//  - Latency: ins_req rises with state IDLE -> mem_req exactly one cycle later; no req -> mem_req stays 0.

Source files
------------

// File: rtl/ysyx_040066_mem_arbiter_if.sv
// Bundle of the three cache-side requester ports, the shared memory port and the grant
// indicator. The "master" view belongs to the arbiter, "slave" to the caches and bus.
interface ysyx_040066_mem_arbiter_if;
    logic         ins_req;
    logic         ins_burst;
    logic [63:0]  ins_addr;
    logic         ins_ready;
    logic         ins_last;
    logic         rd_req;
    logic         rd_burst;
    logic [2:0]   rd_len;
    logic [63:0]  rd_addr;
    logic         rd_ready;
    logic         rd_last;
    logic         wr_req;
    logic         wr_burst;
    logic [2:0]   wr_len;
    logic [7:0]   wr_mask;
    logic [63:0]  wr_addr;
    logic [511:0] wr_data;
    logic         wr_ready;
    logic         rsp_err;
    logic [63:0]  rsp_data;
    logic         mem_req;
    logic         mem_we;
    logic         mem_burst;
    logic [2:0]   mem_len;
    logic [7:0]   mem_mask;
    logic [63:0]  mem_addr;
    logic [511:0] mem_wdata;
    logic         mem_ready;
    logic         mem_last;
    logic         mem_err;
    logic [63:0]  mem_rdata;
    logic [1:0]   grant;

    modport master (
        input  ins_req, ins_burst, ins_addr,
        input  rd_req, rd_burst, rd_len, rd_addr,
        input  wr_req, wr_burst, wr_len, wr_mask, wr_addr, wr_data,
        input  mem_ready, mem_last, mem_err, mem_rdata,
        output ins_ready, ins_last, rd_ready, rd_last, wr_ready,
        output rsp_err, rsp_data,
        output mem_req, mem_we, mem_burst, mem_len, mem_mask, mem_addr, mem_wdata,
        output grant
    );

    modport slave (
        output ins_req, ins_burst, ins_addr,
        output rd_req, rd_burst, rd_len, rd_addr,
        output wr_req, wr_burst, wr_len, wr_mask, wr_addr, wr_data,
        output mem_ready, mem_last, mem_err, mem_rdata,
        input  ins_ready, ins_last, rd_ready, rd_last, wr_ready,
        input  rsp_err, rsp_data,
        input  mem_req, mem_we, mem_burst, mem_len, mem_mask, mem_addr, mem_wdata,
        input  grant
    );
endinterface

// File: rtl/ysyx_040066_mem_arbiter.sv
// Three-way memory port arbiter: DW > DR > I fixed priority, with I forced after
// STARVE_LIMIT consecutive D grants while it waits. Grants are registered in IDLE only.
module ysyx_040066_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_040066_mem_arbiter_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_I  = 2'd1,
        GNT_DR = 2'd2,
        GNT_DW = 2'd3
    } state_e;

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       done_s;

    // State register and starvation counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Arbitration in IDLE, completion detection while granted
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        done_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ins_req && (starve_q == LIMIT_C)) begin
                    state_d = GNT_I;
                end else if (bus.wr_req) begin
                    state_d = GNT_DW;
                end else if (bus.rd_req) begin
                    state_d = GNT_DR;
                end else if (bus.ins_req) begin
                    state_d = GNT_I;
                end else begin
                    state_d = IDLE;
                end
                // Count only D grants that overtake a waiting I
                if (state_d == IDLE) begin
                    starve_d = starve_q;
                end else if ((state_d != GNT_I) && bus.ins_req) begin
                    starve_d = (starve_q >= LIMIT_C) ? LIMIT_C : (starve_q + 4'd1);
                end else begin
                    starve_d = 4'd0;
                end
            end
            GNT_I, GNT_DR: begin
                done_s  = bus.mem_ready & bus.mem_last;
                state_d = done_s ? IDLE : state_q;
            end
            GNT_DW: begin
                done_s  = bus.mem_ready;
                state_d = done_s ? IDLE : state_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus fields and return path, selected by the current grant
    always_comb begin
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_burst = 1'b0;
        bus.mem_len   = 3'd0;
        bus.mem_mask  = 8'd0;
        bus.mem_addr  = 64'd0;
        bus.mem_wdata = 512'd0;
        bus.ins_ready = 1'b0;
        bus.ins_last  = 1'b0;
        bus.rd_ready  = 1'b0;
        bus.rd_last   = 1'b0;
        bus.wr_ready  = 1'b0;
        bus.rsp_err   = 1'b0;
        bus.rsp_data  = 64'd0;
        bus.grant     = state_q;
        case (state_q)
            GNT_I: begin
                bus.mem_req   = 1'b1;
                bus.mem_burst = bus.ins_burst;
                bus.mem_len   = 3'd3;
                bus.mem_addr  = bus.ins_addr;
                bus.ins_ready = bus.mem_ready;
                bus.ins_last  = bus.mem_last;
            end
            GNT_DR: begin
                bus.mem_req   = 1'b1;
                bus.mem_burst = bus.rd_burst;
                bus.mem_len   = bus.rd_len;
                bus.mem_addr  = bus.rd_addr;
                bus.rd_ready  = bus.mem_ready;
                bus.rd_last   = bus.mem_last;
            end
            GNT_DW: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_burst = bus.wr_burst;
                bus.mem_len   = bus.wr_len;
                bus.mem_mask  = bus.wr_mask;
                bus.mem_addr  = bus.wr_addr;
                bus.mem_wdata = bus.wr_data;
                bus.wr_ready  = bus.mem_ready;
            end
            default: begin
                bus.mem_req   = 1'b0;
            end
        endcase
        if (state_q != IDLE) begin
            bus.rsp_data = bus.mem_rdata;
            bus.rsp_err  = bus.mem_err & bus.mem_ready;
        end else begin
            bus.rsp_data = 64'd0;
            bus.rsp_err  = 1'b0;
        end
    end
endmodule
